mem_io_responder: RTL and testbench
===================================

// Module: mem_io_responder
// PURPOSE
// Responder for the CPU byte-wide memory bus (cpu_a/cpu_dout/cpu_wr in, cpu_din out). Holds a RAM
// of 2**RAM_AW bytes and the memory-mapped I/O window where cpu_a[17:16]==2'b11.
// In that window, 0x30000 is the UART byte in/out and 0x30004 is the cycle counter / program-stop port.
// The block also generates io_buffer_full from its TX FIFO, and sits beside cpu in the system top.
// PARAMETERS
// RAM_AW       17  RAM address width in bytes (17 = 128KB)
// TX_DEPTH     16  TX FIFO depth in bytes, power of 2, >=4
// FULL_MARGIN   2  io_buffer_full asserts when TX FIFO count >= TX_DEPTH-FULL_MARGIN
// PORTS
// clk_in          in   1   system clock
// rst_in          in   1   reset; asynchronous, active-high
// rdy_in          in   1   bus enable; when low, no access is performed and all state is frozen except tx pop
// cpu_a           in   32  byte address; only bits [17:0] are decoded
// cpu_dout        in   8   write data from CPU
// cpu_wr          in   1   1 = write, 0 = read
// cpu_din         out  8   read data, valid the cycle after the read address
// io_buffer_full  out  1   TX FIFO nearly full
// tx_data         out  8   byte to UART transmitter (FIFO head)
// tx_valid        out  1   TX FIFO non-empty
// tx_ready        in   1   UART accepts tx_data this cycle when tx_valid&tx_ready
// rx_data         in   8   byte from UART receiver
// rx_valid        in   1   rx_data holds an unread byte
// rx_pop          out  1   1-cycle pulse: rx byte consumed
// tx_overflow     out  1   sticky: a TX push was dropped because the FIFO was full
// program_done    out  1   high once the stop sequence has completed
// BEHAVIOUR
// - Reset: cpu_din=0, FIFO empty (tx_valid=0), rx_pop=0, tx_overflow=0, program_done=0, counter=0, state RUN.
//   RAM contents are not reset.
// - Decode (rdy_in=1): io = cpu_a[17:16]==2'b11; otherwise RAM index = cpu_a[RAM_AW-1:0].
// - RAM write: ram[idx]<=cpu_dout at the edge. RAM read: cpu_din<=ram[idx] at the edge (1-cycle latency).
//   A write cycle leaves cpu_din unchanged.
// - IO read 0x30000: if rx_valid, then cpu_din<=rx_data and rx_pop=1 for that cycle; otherwise cpu_din<=0x00.
// - IO read 0x30004..0x30007: cpu_din<=counter byte cpu_a[1:0], little-endian.
//   A read of 0x30004 also latches a snapshot; 0x30005..7 return snapshot bytes, so a 4-byte read is coherent.
// - IO write 0x30000: push cpu_dout into the TX FIFO; a write of 0x00 is ignored.
// - IO write 0x30004: push 0x00 into the TX FIFO and enter DRAIN.
// - Other IO addresses: reads return 0x00; writes are ignored.
// - Counter: 32-bit, +1 every clk_in with rdy_in=1 while in RUN, wraps 0xFFFFFFFF->0. Frozen in DRAIN/HALTED.
// - TX FIFO: push and pop may occur in the same cycle, and count is unchanged.
//   If the FIFO is full: a push that coincides with a pop succeeds; otherwise the byte is dropped and tx_overflow is set.
//   io_buffer_full is registered from count (count >= TX_DEPTH-FULL_MARGIN). Read/write pointers wrap mod TX_DEPTH.
// - FSM:
//   RUN    -> DRAIN  on an IO write to 0x30004.
//   DRAIN  -> HALTED when the FIFO is empty and there is no push this cycle.
//   HALTED: program_done=1; all CPU writes are ignored, reads still served. Only reset leaves HALTED.
//   In DRAIN, RAM accesses are still served, further TX pushes are ignored, and the 0x00 stop byte has already been queued.
// - If a stop write occurs while the FIFO is full without a pop, the 0x00 byte is dropped (overflow) and DRAIN still entered.
// - Reset asserted mid-access: the access is aborted; the write does not occur.
// TESTING
// - Write 0xA5 to 0x00123, then read 0x00123 -> cpu_din=0xA5 exactly 1 cycle after the read address.
// - Write 'H',0x00,'i' to 0x30000 with tx_ready=1 -> tx_data sequence 0x48,0x69 only; tx_overflow=0.
// - tx_ready=0, push 14 bytes -> io_buffer_full=1 after the 14th; push 3 more -> tx_overflow=1; FIFO holds the first 16 in order.
// - Run 0x1234 cycles, then read 0x30004..7 -> bytes equal the counter at the 0x30004 read, little-endian; the counter wraps at 2^32 (force).
// - rx_valid=1, rx_data=0x37, read 0x30000 -> rx_pop pulse, cpu_din=0x37; with rx_valid=0 -> cpu_din=0x00, no pulse.
// - Write 0x30004 with 3 bytes queued, tx_ready=1 -> the 3 bytes then 0x00 are sent, then program_done=1; toggling rdy_in=0 stalls all.

Source files
------------

// File: rtl/mem_io_responder.sv
// CPU byte-bus responder: RAM, memory-mapped UART TX FIFO / RX port, cycle counter
// and the program-stop (drain then halt) handshake.
module mem_io_responder #(
  parameter int unsigned RAM_AW      = 17,
  parameter int unsigned TX_DEPTH    = 16,
  parameter int unsigned FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        tx_overflow,
  output logic        program_done
);

  localparam int unsigned RAM_SIZE = 1 << RAM_AW;
  localparam int unsigned PTR_W    = $clog2(TX_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned FULL_TH  = TX_DEPTH - FULL_MARGIN;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [7:0]       cpu_din_q, cpu_din_d;
  logic [31:0]      counter_q, counter_d;
  logic [31:0]      snap_q, snap_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tx_valid_q, tx_valid_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [7:0] ram_q  [RAM_SIZE];
  logic [7:0] fifo_q [TX_DEPTH];

  logic [RAM_AW-1:0] ram_idx;
  logic              is_io, io_uart, io_stop, io_cnt;
  logic              rd_en, wr_en, ram_we;
  logic              push_req, push_ok, pop;
  logic [7:0]        push_data;
  logic              unused_a;

  // Address decode; only cpu_a[17:0] is significant
  assign ram_idx   = cpu_a[RAM_AW-1:0];
  assign is_io     = (cpu_a[17:16] == 2'b11);
  assign io_uart   = is_io && (cpu_a[15:0] == 16'h0000);
  assign io_stop   = is_io && (cpu_a[15:0] == 16'h0004);
  assign io_cnt    = is_io && (cpu_a[15:2] == 14'h0001);
  assign unused_a  = ^cpu_a[31:18];

  assign rd_en     = rdy_in && !cpu_wr;
  assign wr_en     = rdy_in && cpu_wr && (state_q != ST_HALT);
  assign ram_we    = wr_en && !is_io;
  assign push_req  = wr_en && (state_q == ST_RUN) && ((io_uart && (cpu_dout != 8'h00)) || io_stop);
  assign push_data = io_stop ? 8'h00 : cpu_dout;
  assign pop       = tx_valid_q && tx_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok   = push_req && ((count_q != CNT_W'(TX_DEPTH)) || pop);

  always_comb begin
    state_d   = state_q;
    cpu_din_d = cpu_din_q;
    counter_d = counter_q;
    snap_d    = snap_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;

    if (rdy_in && (state_q == ST_RUN)) counter_d = counter_q + 32'd1;

    if (rd_en) begin
      if (!is_io) begin
        cpu_din_d = ram_q[ram_idx];
      end else if (io_uart) begin
        cpu_din_d = rx_valid ? rx_data : 8'h00;
      end else if (io_cnt) begin
        // Byte 0 reads live and snapshots, so bytes 1..3 belong to the same count
        case (cpu_a[1:0])
          2'd0: begin
            cpu_din_d = counter_q[7:0];
            snap_d    = counter_q;
          end
          2'd1:    cpu_din_d = snap_q[15:8];
          2'd2:    cpu_din_d = snap_q[23:16];
          default: cpu_din_d = snap_q[31:24];
        endcase
      end else begin
        cpu_din_d = 8'h00;
      end
    end

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (push_req && !push_ok) ovf_d = 1'b1;

    case (state_q)
      ST_RUN:   if (wr_en && io_stop) state_d = ST_DRAIN;
      ST_DRAIN: if (rdy_in && (count_q == CNT_W'(0)) && !push_ok) state_d = ST_HALT;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RUN;
    endcase

    tx_valid_d = (count_d != CNT_W'(0));
    full_d     = (count_d >= CNT_W'(FULL_TH));
    done_d     = (state_d == ST_HALT);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_RUN;
      cpu_din_q  <= 8'h00;
      counter_q  <= 32'h0;
      snap_q     <= 32'h0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      tx_valid_q <= 1'b0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpu_din_q  <= cpu_din_d;
      counter_q  <= counter_d;
      snap_q     <= snap_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      tx_valid_q <= tx_valid_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  // RAM is not cleared; a write presented while reset is high is discarded
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (!rst_in && ram_we) ram_q[ram_idx] <= cpu_dout;
  end

  always_ff @(posedge clk_in) begin
    if (push_ok) fifo_q[wr_ptr_q] <= push_data;
  end

  // rx_pop marks the read cycle itself so the UART can retire the byte at that edge
  assign rx_pop         = !rst_in && rd_en && io_uart && rx_valid;
  assign cpu_din        = cpu_din_q;
  assign io_buffer_full = full_q;
  assign tx_data        = fifo_q[rd_ptr_q];
  assign tx_valid       = tx_valid_q;
  assign tx_overflow    = ovf_q;
  assign program_done   = done_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: a bus model predicts read data, TX bytes,
// FIFO occupancy, counter and FSM state; queues hold expected read data and TX bytes.
module tb_mem_io_responder;

  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_HALT  = 2;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, cpu_wr, tx_ready, rx_valid;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout, rx_data;
  logic [7:0]  cpu_din, tx_data;
  logic        io_buffer_full, tx_valid, rx_pop, tx_overflow, program_done;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_din [$];
  logic [7:0]  exp_tx  [$];
  logic [7:0]  mram [int];
  int          mcount, mstate;
  bit          mov;
  logic [31:0] mcnt, msnap, got;
  logic [7:0]  mdin;

  mem_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
    .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
    .tx_overflow(tx_overflow), .program_done(program_done)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // TX scoreboard: every byte the DUT hands over must be the next one queued
  always @(negedge clk_in) begin
    if (!rst_in && tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) chk("tx_extra_valid", 32'(tx_valid), 32'h0);
      else chk("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
    end
  end

  task automatic do_reset(input logic [31:0] a, input logic wr, input logic [7:0] d);
    rst_in = 1'b1; rdy_in = 1'b1; cpu_a = a; cpu_wr = wr; cpu_dout = d;
    exp_tx.delete(); exp_din.delete();
    mcount = 0; mstate = M_RUN; mov = 1'b0; mcnt = 32'h0; msnap = 32'h0; mdin = 8'h00;
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_cpu_din", 32'(cpu_din), 32'h0);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_rx_pop", 32'(rx_pop), 32'h0);
    chk("rst_tx_overflow", 32'(tx_overflow), 32'h0);
    chk("rst_program_done", 32'(program_done), 32'h0);
    chk("rst_io_buffer_full", 32'(io_buffer_full), 32'h0);
    rst_in = 1'b0;
  endtask

  // One bus cycle: drive, predict, clock, compare
  task automatic bus(input logic rdy, input logic [31:0] a, input logic wr, input logic [7:0] d);
    logic [15:0] off;
    logic [7:0]  e;
    logic [31:0] snap_n;
    bit          io, rd, push, acc, pop_now, exp_pop;
    rdy_in = rdy; cpu_a = a; cpu_wr = wr; cpu_dout = d;
    io = (a[17:16] == 2'b11);
    off = a[15:0];
    rd = rdy && !wr;
    e = 8'h00;
    snap_n = msnap;
    if (rd) begin
      if (!io) e = mram.exists(int'(a[16:0])) ? mram[int'(a[16:0])] : 8'h00;
      else if (off == 16'h0000) e = rx_valid ? rx_data : 8'h00;
      else if (off == 16'h0004) begin e = mcnt[7:0]; snap_n = mcnt; end
      else if (off == 16'h0005) e = msnap[15:8];
      else if (off == 16'h0006) e = msnap[23:16];
      else if (off == 16'h0007) e = msnap[31:24];
      exp_din.push_back(e);
    end
    exp_pop = rd && io && (off == 16'h0000) && rx_valid;
    push = rdy && wr && (mstate == M_RUN) && io && (((off == 16'h0000) && (d != 8'h00)) || (off == 16'h0004));
    pop_now = tx_ready && (mcount != 0);
    acc = push && ((mcount < 16) || pop_now);
    if (acc) exp_tx.push_back((off == 16'h0004) ? 8'h00 : d);
    #1;
    chk("rx_pop", 32'(rx_pop), 32'(exp_pop));
    @(posedge clk_in);
    if (push && !acc) mov = 1'b1;
    if (rdy && wr && !io && (mstate != M_HALT)) mram[int'(a[16:0])] = d;
    if (rdy && (mstate == M_RUN)) mcnt = mcnt + 32'd1;
    msnap = snap_n;
    if (rdy) begin
      if ((mstate == M_RUN) && wr && io && (off == 16'h0004)) mstate = M_DRAIN;
      else if ((mstate == M_DRAIN) && (mcount == 0)) mstate = M_HALT;
    end
    mcount = mcount + int'(acc) - int'(pop_now);
    #1;
    if (rd) begin
      mdin = exp_din.pop_front();
      chk("cpu_din", 32'(cpu_din), 32'(mdin));
    end else begin
      chk("cpu_din_hold", 32'(cpu_din), 32'(mdin));
    end
    chk("tx_valid", 32'(tx_valid), 32'(mcount != 0));
    chk("io_buffer_full", 32'(io_buffer_full), 32'(mcount >= 14));
    chk("tx_overflow", 32'(tx_overflow), 32'(mov));
    chk("program_done", 32'(program_done), 32'(mstate == M_HALT));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b1, 32'h0, 1'b0, 8'h00);
  endtask

  task automatic read_cnt_word();
    for (int k = 0; k < 4; k++) begin
      bus(1'b1, 32'h30004 + 32'(k), 1'b0, 8'h00);
      got[8*k +: 8] = cpu_din;
    end
    chk("cnt_word_coherent", got, msnap);
  endtask

  initial begin
    tx_ready = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    do_reset(32'h0, 1'b0, 8'h00);

    // RAM write then read, 1-cycle latency
    bus(1'b1, 32'h00000, 1'b1, 8'h5A);
    bus(1'b1, 32'h00123, 1'b1, 8'hA5);
    bus(1'b1, 32'h00123, 1'b0, 8'h00);
    chk("ram_a5", 32'(cpu_din), 32'hA5);
    bus(1'b1, 32'h1FFFF, 1'b1, 8'hC3);
    bus(1'b1, 32'h1FFFF, 1'b0, 8'h00);

    // 'H', 0x00 (ignored), 'i'
    bus(1'b1, 32'h30000, 1'b1, 8'h48);
    bus(1'b1, 32'h30000, 1'b1, 8'h00);
    bus(1'b1, 32'h30000, 1'b1, 8'h69);
    idle(4);
    chk("hi_drained", 32'(exp_tx.size()), 32'h0);

    // Fill to threshold, then overflow
    tx_ready = 1'b0;
    for (int i = 0; i < 13; i++) bus(1'b1, 32'h30000, 1'b1, 8'h10 + 8'(i));
    chk("full_at_13", 32'(io_buffer_full), 32'h0);
    bus(1'b1, 32'h30000, 1'b1, 8'h1D);
    idle(1);
    chk("full_at_14", 32'(io_buffer_full), 32'h1);
    for (int i = 0; i < 3; i++) bus(1'b1, 32'h30000, 1'b1, 8'h1E + 8'(i));
    chk("overflow_sticky", 32'(tx_overflow), 32'h1);
    chk("fifo_holds_16", 32'(exp_tx.size()), 32'd16);
    tx_ready = 1'b1;
    idle(20);
    chk("fifo_drained", 32'(exp_tx.size()), 32'h0);

    // RX port and unmapped IO
    rx_valid = 1'b1; rx_data = 8'h37;
    bus(1'b0, 32'h30000, 1'b0, 8'h00);
    bus(1'b1, 32'h30000, 1'b0, 8'h00);
    chk("rx_byte", 32'(cpu_din), 32'h37);
    rx_valid = 1'b0;
    bus(1'b1, 32'h30000, 1'b0, 8'h00);
    bus(1'b1, 32'h30008, 1'b0, 8'h00);
    bus(1'b1, 32'h30010, 1'b1, 8'h55);

    // Counter after 0x1234 cycles, then forced wrap
    do_reset(32'h0, 1'b0, 8'h00);
    idle(32'h1234);
    read_cnt_word();
    force dut.counter_q = 32'hFFFF_FFFE;
    #1;
    release dut.counter_q;
    mcnt = 32'hFFFF_FFFE;
    idle(3);
    read_cnt_word();
    chk("cnt_wrap", got, 32'h0000_0001);

    // Stop sequence with rdy_in toggling
    tx_ready = 1'b0;
    bus(1'b1, 32'h30000, 1'b1, 8'hA1);
    bus(1'b1, 32'h30000, 1'b1, 8'hA2);
    bus(1'b1, 32'h30000, 1'b1, 8'hA3);
    bus(1'b1, 32'h30004, 1'b1, 8'h00);
    bus(1'b1, 32'h30000, 1'b1, 8'h5A);
    bus(1'b1, 32'h00200, 1'b1, 8'h77);
    bus(1'b1, 32'h00200, 1'b0, 8'h00);
    read_cnt_word();
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) bus(1'b0, 32'h0, 1'b0, 8'h00);
    chk("drain_stalled", 32'(program_done), 32'h0);
    for (int i = 0; i < 6; i++) bus(1'(i % 2), 32'h0, 1'b0, 8'h00);
    chk("halted", 32'(program_done), 32'h1);
    chk("stop_bytes_sent", 32'(exp_tx.size()), 32'h0);
    bus(1'b1, 32'h00200, 1'b1, 8'h99);
    bus(1'b1, 32'h00200, 1'b0, 8'h00);
    chk("halt_write_ignored", 32'(cpu_din), 32'h77);
    bus(1'b1, 32'h30000, 1'b1, 8'h42);
    read_cnt_word();

    // Reset during a write aborts it
    do_reset(32'h0, 1'b0, 8'h00);
    bus(1'b1, 32'h00300, 1'b1, 8'h11);
    do_reset(32'h00300, 1'b1, 8'hEE);
    bus(1'b1, 32'h00300, 1'b0, 8'h00);
    chk("reset_aborts_write", 32'(cpu_din), 32'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
